// File: rtl/pc_sequencer_if.sv
// Bus between pc_sequencer and its PC unit, instruction memory and decode.
// master is the sequencer's view; slave is the surrounding system's view.
interface pc_sequencer_if;
  logic [15:0] pc_cur;
  logic        pc_en;
  logic [1:0]  pc_op;
  logic [15:0] pc_target;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_valid;
  logic [15:0] br_target;
  logic        br_ack;
  logic        stall;
  logic        fault;
  logic        irq;
  logic        irq_ack;
  logic [15:0] epc;

  modport master (
    input  pc_cur, fetch_ack, fetch_data, instr_ready, br_valid, br_target, stall, irq,
    output pc_en, pc_op, pc_target, fetch_req, fetch_addr, instr_out, instr_valid,
           br_ack, fault, irq_ack, epc
  );

  modport slave (
    output pc_cur, fetch_ack, fetch_data, instr_ready, br_valid, br_target, stall, irq,
    input  pc_en, pc_op, pc_target, fetch_req, fetch_addr, instr_out, instr_valid,
           br_ack, fault, irq_ack, epc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/issue controller driving the PC unit, instruction fetch and decode handoff.
// Optional interrupt entry is enabled by defining PC_SEQ_IRQ_EN.
module pc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] IRQ_VECTOR     = 16'h0004
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  typedef enum logic [1:0] {RST, FETCH, ISSUE, FAULT} state_t;

  state_t      state;
  logic [15:0] count;
  logic        issuing;
  logic        take_br;
  logic        take_irq;
  logic        take_inc;
  logic        reset_pulse;

  // PC-unit controls are decided in the issuing cycle itself so the PC has
  // already moved by the time FETCH presents it as fetch_addr.
  always_comb begin
    issuing     = (state == ISSUE) && !bus.stall;
    reset_pulse = rst_n && (state == RST);
    take_br     = issuing && bus.br_valid;
`ifdef PC_SEQ_IRQ_EN
    take_irq    = issuing && !bus.br_valid && bus.irq;
`else
    take_irq    = 1'b0;
`endif
    take_inc    = issuing && !bus.br_valid && !take_irq && bus.instr_ready;

    bus.pc_en     = reset_pulse || take_br || take_irq || take_inc;
    bus.pc_op     = PC_NOP;
    bus.pc_target = '0;
    if (reset_pulse) begin
      bus.pc_op = PC_RESET;
    end else if (take_br) begin
      bus.pc_op     = PC_SET;
      bus.pc_target = bus.br_target;
    end else if (take_irq) begin
      bus.pc_op     = PC_SET;
      bus.pc_target = IRQ_VECTOR;
    end else if (take_inc) begin
      bus.pc_op = PC_INC;
    end
    bus.br_ack     = take_br;
    bus.irq_ack    = take_irq;
    bus.fetch_addr = bus.pc_cur;
  end

`ifndef PC_SEQ_IRQ_EN
  logic unused_irq;
  assign unused_irq = bus.irq;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= RST;
      count           <= '0;
      bus.fault       <= 1'b0;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.epc         <= '0;
      bus.fetch_req   <= 1'b0;
    end else begin
      case (state)
        RST: begin
          state         <= FETCH;
          bus.fetch_req <= 1'b1;
        end
        FETCH: begin
          if (bus.fetch_ack) begin
            bus.instr_out   <= bus.fetch_data;
            bus.instr_valid <= 1'b1;
            bus.fetch_req   <= 1'b0;
            count           <= '0;
            state           <= ISSUE;
          end else if (count == 16'(TIMEOUT_CYCLES - 1)) begin
            bus.fault     <= 1'b1;
            bus.fetch_req <= 1'b0;
            state         <= FAULT;
          end else begin
            count <= count + 16'd1;
          end
        end
        ISSUE: begin
          if (take_br || take_irq || take_inc) begin
            bus.instr_valid <= 1'b0;
            bus.fetch_req   <= 1'b1;
            state           <= FETCH;
          end
`ifdef PC_SEQ_IRQ_EN
          if (take_irq) bus.epc <= bus.pc_cur + 16'd2;
`endif
        end
        FAULT: state <= FAULT;
        default: state <= RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC unit and fetch responder.
module tb_pc_sequencer;
  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  logic ack_en;
  logic req_d;
  logic [15:0] fetch_count;
  logic [15:0] pc_model;
  int checks = 0;
  int errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.TIMEOUT_CYCLES(4), .IRQ_VECTOR(16'h0004)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // PC unit: +2 per instruction; memory acks one cycle after a request appears.
  always @(posedge clk) begin
    if (!rst_n) begin
      req_d       <= 1'b0;
      fetch_count <= '0;
    end else begin
      req_d <= bus.fetch_req && !bus.fetch_ack;
      if (bus.fetch_ack) fetch_count <= fetch_count + 16'd1;
    end
    if (bus.pc_en) begin
      case (bus.pc_op)
        PC_RESET: pc_model <= 16'h0000;
        PC_INC:   pc_model <= pc_model + 16'd2;
        PC_SET:   pc_model <= bus.pc_target;
        default:  pc_model <= pc_model;
      endcase
    end
  end

  assign bus.pc_cur     = pc_model;
  assign bus.fetch_ack  = ack_en && bus.fetch_req && req_d;
  assign bus.fetch_data = 16'hA000 + fetch_count;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fetch_one(input logic [15:0] a, input logic [15:0] d, input string tag);
    int n = 0;
    while (bus.fetch_ack !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++; if (bus.fetch_ack !== 1'b1) begin errors++; $display("FAIL %s_ack: got %b want 1", tag, bus.fetch_ack); end
    checks++; if (bus.fetch_addr !== a) begin errors++; $display("FAIL %s_addr: got %h want %h", tag, bus.fetch_addr, a); end
    cyc();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== d) begin errors++; $display("FAIL %s_instr: got v=%b %h want v=1 %h", tag, bus.instr_valid, bus.instr_out, d); end
  endtask

  task automatic issue_inc(input string tag);
    bus.instr_ready = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_op !== PC_INC) begin errors++; $display("FAIL %s_inc: got en=%b op=%0d want en=1 op=%0d", tag, bus.pc_en, bus.pc_op, PC_INC); end
    cyc();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.fetch_req !== 1'b0 || bus.pc_en !== 1'b0 || bus.pc_op !== PC_NOP) begin errors++; $display("FAIL reset_ctrl: got req=%b en=%b op=%0d want 0 0 0", bus.fetch_req, bus.pc_en, bus.pc_op); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0) begin errors++; $display("FAIL reset_instr: got v=%b %h want 0 0000", bus.instr_valid, bus.instr_out); end
    checks++; if (bus.fault !== 1'b0 || bus.br_ack !== 1'b0 || bus.irq_ack !== 1'b0) begin errors++; $display("FAIL reset_flags: got f=%b b=%b i=%b want 0 0 0", bus.fault, bus.br_ack, bus.irq_ack); end
    checks++; if (bus.epc !== 16'h0 || bus.pc_target !== 16'h0) begin errors++; $display("FAIL reset_regs: got epc=%h tgt=%h want 0 0", bus.epc, bus.pc_target); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_op !== PC_RESET) begin errors++; $display("FAIL reset_pulse: got en=%b op=%0d want 1 %0d", bus.pc_en, bus.pc_op, PC_RESET); end
    cyc();
    checks++; if (bus.pc_en !== 1'b0 || bus.fetch_req !== 1'b1) begin errors++; $display("FAIL reset_single_pulse: got en=%b req=%b want 0 1", bus.pc_en, bus.fetch_req); end
  endtask

  task automatic test_run();
    for (int n = 0; n < 4; n++) begin
      fetch_one(16'(2 * n), 16'hA000 + 16'(n), "run");
      issue_inc("run");
    end
  endtask

  task automatic test_branch();
    do_reset();
    cyc();
    fetch_one(16'h0000, 16'hA000, "br_pre0");
    issue_inc("br_pre0");
    fetch_one(16'h0002, 16'hA001, "br_pre1");
    issue_inc("br_pre1");
    fetch_one(16'h0004, 16'hA002, "br_pre2");
    bus.br_valid = 1'b1; bus.br_target = 16'h0100; bus.instr_ready = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_op !== PC_SET || bus.pc_target !== 16'h0100) begin errors++; $display("FAIL br_set: got en=%b op=%0d tgt=%h want 1 %0d 0100", bus.pc_en, bus.pc_op, bus.pc_target, PC_SET); end
    checks++; if (bus.br_ack !== 1'b1) begin errors++; $display("FAIL br_ack: got %b want 1", bus.br_ack); end
    cyc();
    bus.br_valid = 1'b0; bus.instr_ready = 1'b0;
    #1;
    checks++; if (bus.br_ack !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL br_after: got ack=%b v=%b en=%b want 0 0 0", bus.br_ack, bus.instr_valid, bus.pc_en); end
    fetch_one(16'h0100, 16'hA003, "br_dest");
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.pc_en !== 1'b0 || bus.br_ack !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_out !== 16'hA003) begin errors++; $display("FAIL stall_hold: cyc %0d en=%b ack=%b v=%b %h want 0 0 1 a003", i, bus.pc_en, bus.br_ack, bus.instr_valid, bus.instr_out); end
      cyc();
    end
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.br_ack !== 1'b1 || bus.pc_op !== PC_SET || bus.pc_target !== 16'h0200) begin errors++; $display("FAIL stall_release: got ack=%b op=%0d tgt=%h want 1 %0d 0200", bus.br_ack, bus.pc_op, bus.pc_target, PC_SET); end
    cyc();
    bus.br_valid = 1'b0;
    fetch_one(16'h0200, 16'hA004, "stall_dest");
  endtask

  task automatic test_wrap();
    bus.br_valid = 1'b1; bus.br_target = 16'hFFFE;
    cyc();
    bus.br_valid = 1'b0;
    fetch_one(16'hFFFE, 16'hA005, "wrap_top");
    issue_inc("wrap");
    fetch_one(16'h0000, 16'hA006, "wrap_zero");
  endtask

  task automatic test_irq();
    bus.br_valid = 1'b1; bus.br_target = 16'h0010;
    cyc();
    bus.br_valid = 1'b0;
    fetch_one(16'h0010, 16'hA007, "irq_pre");
    bus.irq = 1'b1;
    #1;
`ifdef PC_SEQ_IRQ_EN
    checks++; if (bus.irq_ack !== 1'b1 || bus.pc_op !== PC_SET || bus.pc_target !== 16'h0004) begin errors++; $display("FAIL irq_take: got ack=%b op=%0d tgt=%h want 1 %0d 0004", bus.irq_ack, bus.pc_op, bus.pc_target, PC_SET); end
    cyc();
    bus.irq = 1'b0;
    #1;
    checks++; if (bus.epc !== 16'h0012 || bus.irq_ack !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL irq_epc: got epc=%h ack=%b v=%b want 0012 0 0", bus.epc, bus.irq_ack, bus.instr_valid); end
    fetch_one(16'h0004, 16'hA008, "irq_vec");
    bus.irq = 1'b1; bus.br_valid = 1'b1; bus.br_target = 16'h0100;
    #1;
    checks++; if (bus.br_ack !== 1'b1 || bus.irq_ack !== 1'b0 || bus.pc_target !== 16'h0100) begin errors++; $display("FAIL irq_br_prio: got br=%b irq=%b tgt=%h want 1 0 0100", bus.br_ack, bus.irq_ack, bus.pc_target); end
    cyc();
    bus.irq = 1'b0; bus.br_valid = 1'b0;
    #1;
    checks++; if (bus.epc !== 16'h0012) begin errors++; $display("FAIL irq_epc_keep: got %h want 0012", bus.epc); end
`else
    checks++; if (bus.irq_ack !== 1'b0 || bus.pc_en !== 1'b0 || bus.epc !== 16'h0) begin errors++; $display("FAIL irq_ignored: got ack=%b en=%b epc=%h want 0 0 0000", bus.irq_ack, bus.pc_en, bus.epc); end
    cyc();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'hA007) begin errors++; $display("FAIL irq_hold: got v=%b %h want 1 a007", bus.instr_valid, bus.instr_out); end
    bus.irq = 1'b0;
`endif
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.fetch_req !== 1'b1 || bus.fault !== 1'b0) begin errors++; $display("FAIL to_wait: cyc %0d req=%b fault=%b want 1 0", i, bus.fetch_req, bus.fault); end
      cyc();
    end
    checks++; if (bus.fault !== 1'b1 || bus.fetch_req !== 1'b0) begin errors++; $display("FAIL to_fault: got fault=%b req=%b want 1 0", bus.fault, bus.fetch_req); end
    bus.instr_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (bus.fault !== 1'b1 || bus.pc_en !== 1'b0 || bus.fetch_req !== 1'b0) begin errors++; $display("FAIL to_sticky: got fault=%b en=%b req=%b want 1 0 0", bus.fault, bus.pc_en, bus.fetch_req); end
    bus.instr_ready = 1'b0;
    ack_en = 1'b1;
    rst_n = 1'b0;
    cyc();
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", bus.fault); end
    cyc();
    rst_n = 1'b1;
    #1;
    cyc();
    fetch_one(16'h0000, 16'hA000, "to_restart");
  endtask

  initial begin
    rst_n = 1'b0; ack_en = 1'b1;
    bus.instr_ready = 1'b0; bus.br_valid = 1'b0; bus.br_target = 16'h0;
    bus.stall = 1'b0; bus.irq = 1'b0;
    test_reset();
    test_run();
    test_branch();
    test_stall();
    test_wrap();
    test_irq();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
